result_writeback: RTL and testbench

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback_pkg.sv | 23 ++
 rtl/result_writeback_wb_fifo.sv | 62 ++++++
 rtl/result_writeback.sv | 168 ++++++++++++++++
 tb/tb_result_writeback.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_writeback_pkg.sv
// rtl/result_writeback_pkg.sv - shared constants and types for the result writeback block
//
// Purpose : FSM state encoding, datapath widths and the lane-select width
//           helper used by result_writeback.
// Ports   : none (package).
package result_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_t;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADR_W  = 8;

  // Lane-select width for a given lane count; never narrower than one bit
  // so a single-lane build still has a legal counter.
  function automatic int lane_sel_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/result_writeback_wb_fifo.sv
// rtl/result_writeback_wb_fifo.sv - synchronous bundle FIFO with full/empty
//
// Purpose : holds accepted result bundles until the writer drains them.
//           DEPTH must be a power of two (>= 2) so the pointers wrap freely.
// Ports   : clk        clock
//           rst        synchronous active-low reset
//           flush      synchronous clear of all entries
//           push       write push_data (ignored when full)
//           push_data  bundle to store
//           pop        drop the head entry (ignored when empty)
//           head_data  current head entry (valid when !empty)
//           full       DEPTH entries held
//           empty      no entries held
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed through the counters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - buffers filter result bundles and writes them lane by lane
//
// Purpose : accepts one bundle of NUM_FILTERS signed 8-bit results per
//           handshake, queues it in wb_fifo and writes each lane to
//           base + lane*OUT_LEN + bundle_index (mod 256). done rises after
//           the last lane of bundle OUT_LEN-1 is written.
// Config  : WB_RELU_EN - when defined, negative lane values are written as 0.
// Ports   : clk          clock
//           rst          synchronous active-low reset
//           start        pulse: load base_adr, clear counters, flush FIFO
//           base_adr     output region base address
//           res_valid    bundle present on res_data
//           res_data     lane f at [8f+7:8f]
//           res_ready    bundle accepted when res_valid & res_ready
//           mem_ready    memory accepts the write this cycle
//           mem_wr_en    write strobe
//           mem_wr_adr   write address
//           mem_wr_data  write data
//           done         pass complete, held until start or reset
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int NUM_FILTERS = 3,
  parameter int OUT_LEN     = 43,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   base_adr,
  input  logic                         res_valid,
  input  logic [8*NUM_FILTERS-1:0]     res_data,
  output logic                         res_ready,
  input  logic                         mem_ready,
  output logic                         mem_wr_en,
  output logic [7:0]                   mem_wr_adr,
  output logic [7:0]                   mem_wr_data,
  output logic                         done
);

  localparam int LANE_W   = lane_sel_w(NUM_FILTERS);
  localparam int CNT_W    = $clog2(OUT_LEN + 1);
  localparam int BUNDLE_W = WB_DATA_W * NUM_FILTERS;

  wb_state_t            state_q;
  wb_state_t            state_d;
  logic [7:0]           base_q;
  logic [LANE_W-1:0]    lane_q;
  logic [CNT_W-1:0]     idx_q;   // bundles fully written this pass
  logic [CNT_W-1:0]     acc_q;   // bundles accepted this pass

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BUNDLE_W-1:0]  fifo_head;
  logic                 push;
  logic                 pop;
  logic                 wr_fire;
  logic                 last_lane;
  logic                 pass_end;
  logic [7:0]           lane_val;
  logic [7:0]           wr_val;
  logic [7:0]           adr_calc;

  assign wr_fire   = mem_wr_en & mem_ready;
  assign last_lane = (lane_q == LANE_W'(NUM_FILTERS - 1));
  assign push      = res_valid & res_ready;
  assign pop       = wr_fire & last_lane;
  assign pass_end  = pop && (idx_q == CNT_W'(OUT_LEN - 1));

  // start also flushes, so an abort mid-pass discards buffered bundles.
  wb_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (push),
    .push_data (res_data),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start wins over completion so a restart on the
  // final write begins a fresh pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start)         state_d = ST_RUN;
        else if (pass_end) state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so res_ready never
  // combinationally follows mem_ready.
  always_comb begin
    res_ready = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_RUN: begin
        res_ready = ~fifo_full && (acc_q < CNT_W'(OUT_LEN));
        mem_wr_en = ~fifo_empty;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Base, lane and bundle counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q <= '0;
      lane_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
    end else if (start) begin
      base_q <= base_adr;
      lane_q <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
    end else begin
      if (push) acc_q <= acc_q + 1'b1;
      if (wr_fire) begin
        if (last_lane) begin
          lane_q <= '0;
          idx_q  <= idx_q + 1'b1;
        end else begin
          lane_q <= lane_q + 1'b1;
        end
      end
    end
  end

  // Head lane select
  always_comb begin
    lane_val = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      if (lane_q == LANE_W'(f)) lane_val = fifo_head[8*f +: 8];
    end
  end

`ifdef WB_RELU_EN
  assign wr_val = lane_val[7] ? 8'h00 : lane_val;
`else
  assign wr_val = lane_val;
`endif

  // 8-bit arithmetic gives the modulo-256 wrap for free.
  assign adr_calc = base_q + 8'(lane_q) * 8'(OUT_LEN) + 8'(idx_q);

  assign mem_wr_adr  = mem_wr_en ? adr_calc : 8'h00;
  assign mem_wr_data = mem_wr_en ? wr_val   : 8'h00;

endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - randomized self-checking bench for result_writeback
module tb_result_writeback;

  localparam int NF = 3;
  localparam int OL = 43;
  localparam int FD = 2;

`ifdef WB_RELU_EN
  localparam logic [7:0] EXP_F0 = 8'h00;
  localparam logic [7:0] EXP_80 = 8'h00;
`else
  localparam logic [7:0] EXP_F0 = 8'hF0;
  localparam logic [7:0] EXP_80 = 8'h80;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [7:0]      base_adr;
  logic            res_valid;
  logic [8*NF-1:0] res_data;
  logic            res_ready;
  logic            mem_ready;
  logic            mem_wr_en;
  logic [7:0]      mem_wr_adr;
  logic [7:0]      mem_wr_data;
  logic            done;

  always #5 clk = ~clk;

  result_writeback #(
    .NUM_FILTERS (NF),
    .OUT_LEN     (OL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_adr    (base_adr),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .mem_ready   (mem_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_adr  (mem_wr_adr),
    .mem_wr_data (mem_wr_data),
    .done        (done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: a pass is a list of pending writes; each accepted
  // bundle appends its NF writes with addresses fixed at acceptance time.
  typedef struct {
    logic [7:0] adr;
    logic [7:0] data;
    int         lane;
  } wr_t;

  wr_t        wq[$];
  int         m_state  = 0;  // 0 idle, 1 running, 2 done
  logic [7:0] m_base   = 8'h00;
  int         m_acc    = 0;
  int         m_popped = 0;

  logic [7:0] log_adr[$];
  logic [7:0] log_data[$];
  int         acc_seen = 0;

  function automatic logic [7:0] exp_val(input logic [7:0] v);
`ifdef WB_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [8*NF-1:0] rand_bundle();
    logic [8*NF-1:0] b;
    for (int f = 0; f < NF; f++)
      b[8*f +: 8] = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom);
    return b;
  endfunction

  // Compare outputs for the current cycle, then advance the model by one edge.
  task automatic cycle();
    logic e_ready;
    logic e_wr;
    e_ready = (m_state == 1) && ((m_acc - m_popped) < FD) && (m_acc < OL);
    e_wr    = (m_state == 1) && (wq.size() > 0);
    chk("res_ready", res_ready, e_ready);
    chk("mem_wr_en", mem_wr_en, e_wr);
    chk("done", done, m_state == 2);
    if (e_wr) begin
      chk("mem_wr_adr", mem_wr_adr, wq[0].adr);
      chk("mem_wr_data", mem_wr_data, wq[0].data);
    end
    if (mem_wr_en && mem_ready) begin
      log_adr.push_back(mem_wr_adr);
      log_data.push_back(mem_wr_data);
    end
    if (res_valid && res_ready) acc_seen++;

    if (!rst) begin
      wq.delete();
      m_state = 0; m_base = 8'h00; m_acc = 0; m_popped = 0;
    end else if (start) begin
      wq.delete();
      m_state = 1; m_base = base_adr; m_acc = 0; m_popped = 0;
    end else if (m_state == 1) begin
      if (e_wr && mem_ready) begin
        if (wq[0].lane == NF - 1) begin
          m_popped++;
          if (m_popped == OL) m_state = 2;
        end
        void'(wq.pop_front());
      end
      if (res_valid && e_ready) begin
        for (int f = 0; f < NF; f++) begin
          wr_t w;
          w.adr  = 8'((int'(m_base) + f * OL + m_acc) % 256);
          w.data = exp_val(res_data[8*f +: 8]);
          w.lane = f;
          wq.push_back(w);
        end
        m_acc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] b);
    base_adr = b; start = 1'b1; res_valid = 1'b0;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_random(input int budget, input int ready_pct);
    int n = 0;
    while (m_state != 2 && n < budget) begin
      res_valid = ($urandom_range(0, 3) != 0);
      res_data  = rand_bundle();
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      cycle();
      n++;
    end
    chk("pass_within_budget", n < budget, 1'b1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_adr = 8'h00;
    res_valid = 1'b0; res_data = '0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk("rst_mem_wr_adr", mem_wr_adr, 8'h00);
    chk("rst_mem_wr_data", mem_wr_data, 8'h00);
    chk("rst_done", done, 1'b0);
    cycle();
    rst = 1'b1;
    res_valid = 1'b1; res_data = rand_bundle();
    repeat (3) cycle();   // valid ignored while idle
    res_valid = 1'b0;

    // Single bundle, three back-to-back lane writes
    log_adr.delete(); log_data.delete();
    do_start(8'd100);
    res_valid = 1'b1; res_data = {8'd3, 8'd2, 8'd1}; mem_ready = 1'b1;
    cycle();
    res_valid = 1'b0;
    repeat (5) cycle();
    chk("single_nwrites", log_adr.size(), 3);
    if (log_adr.size() == 3) begin
      chk("single_adr0", log_adr[0], 8'd100); chk("single_dat0", log_data[0], 8'd1);
      chk("single_adr1", log_adr[1], 8'd143); chk("single_dat1", log_data[1], 8'd2);
      chk("single_adr2", log_adr[2], 8'd186); chk("single_dat2", log_data[2], 8'd3);
    end

    // Negative lane values
    log_adr.delete(); log_data.delete();
    do_start(8'h10);
    res_valid = 1'b1; res_data = {8'hF0, 8'h80, 8'h05}; mem_ready = 1'b1;
    cycle();
    res_valid = 1'b0;
    repeat (5) cycle();
    chk("relu_nwrites", log_data.size(), 3);
    if (log_data.size() == 3) begin
      chk("relu_lane0", log_data[0], 8'h05);
      chk("relu_lane1", log_data[1], EXP_80);
      chk("relu_lane2", log_data[2], EXP_F0);
    end

    // Backpressure: memory stalled with back-to-back valid
    log_adr.delete(); log_data.delete();
    do_start(8'd5);
    acc_seen = 0;
    mem_ready = 1'b0; res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_data = rand_bundle();
      cycle();
    end
    chk("bp_accepted", acc_seen, 2);
    chk("bp_ready_low", res_ready, 1'b0);
    chk("bp_no_writes", log_adr.size(), 0);
    res_valid = 1'b0; mem_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_drained", log_adr.size(), 6);

    // Full pass with random handshakes (restart from running aborts)
    log_adr.delete(); log_data.delete();
    do_start(8'd200);
    run_random(3000, 60);
    chk("pass_done", done, 1'b1);
    chk("pass_nwrites", log_adr.size(), 3 * OL);
    if (log_adr.size() > 32) chk("pass_adr_b10_l2", log_adr[32], 8'd40);
    res_valid = 1'b1;
    repeat (4) cycle();
    chk("pass_ready_after", res_ready, 1'b0);
    res_valid = 1'b0;

    // Abort mid-pass with a new base, then complete
    do_start(8'd7);
    for (int i = 0; i < 10; i++) begin
      res_valid = 1'b1; res_data = rand_bundle();
      mem_ready = ($urandom_range(0, 1) != 0);
      cycle();
    end
    log_adr.delete(); log_data.delete();
    do_start(8'd250);
    run_random(3000, 75);
    chk("abort_done", done, 1'b1);
    chk("abort_nwrites", log_adr.size(), 3 * OL);

    // Reset after two of three lanes written
    do_start(8'd20);
    res_valid = 1'b1; res_data = rand_bundle(); mem_ready = 1'b1;
    cycle();
    res_valid = 1'b0;
    log_adr.delete(); log_data.delete();
    cycle();
    cycle();
    rst = 1'b0; mem_ready = 1'b0;
    cycle();
    rst = 1'b1; mem_ready = 1'b1;
    chk("mid_rst_res_ready", res_ready, 1'b0);
    chk("mid_rst_mem_wr_en", mem_wr_en, 1'b0);
    chk("mid_rst_mem_wr_adr", mem_wr_adr, 8'h00);
    chk("mid_rst_mem_wr_data", mem_wr_data, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    res_valid = 1'b1;
    repeat (5) cycle();
    res_valid = 1'b0;
    chk("mid_rst_writes", log_adr.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
